flag_int_unit: RTL and testbench



---
 rtl/flag_int_unit.sv | 139 +++++++++++++
 tb/tb_flag_int_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/flag_int_unit.sv
// Processor status flags (C, Z, I) with one-level shadow C/Z, and interrupt
// pending/request sequencing for the control unit.
module flag_int_unit #(
  parameter bit INT_EDGE    = 1'b1,
  parameter bit RETI_SETS_I = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic c_alu,
  input  logic z_alu,
  input  logic flg_c_ld,
  input  logic flg_c_set,
  input  logic flg_c_clr,
  input  logic flg_z_ld,
  input  logic int_set,
  input  logic int_clr,
  input  logic intr,
  input  logic int_take,
  input  logic flg_restore,
  output logic c_flag,
  output logic z_flag,
  output logic i_flag,
  output logic int_req,
  output logic in_isr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   c_q, c_d;
  logic   z_q, z_d;
  logic   i_q, i_d;
  logic   shadow_c_q, shadow_c_d;
  logic   shadow_z_q, shadow_z_d;
  logic   pending_q, pending_d;
  logic   intr_d_q;
  logic   int_req_q;
  logic   take_acc;

  // int_take only counts while a request is actually outstanding
  assign take_acc = int_take & (state_q == REQ);

  always_comb begin
    c_d        = c_q;
    z_d        = z_q;
    i_d        = i_q;
    shadow_c_d = shadow_c_q;
    shadow_z_d = shadow_z_q;

    if (take_acc) begin
      c_d        = 1'b0;
      shadow_c_d = c_q;
    end else if (flg_restore) begin
      c_d = shadow_c_q;
    end else if (flg_c_clr) begin
      c_d = 1'b0;
    end else if (flg_c_set) begin
      c_d = 1'b1;
    end else if (flg_c_ld) begin
      c_d = c_alu;
    end

    if (take_acc) begin
      z_d        = 1'b0;
      shadow_z_d = z_q;
    end else if (flg_restore) begin
      z_d = shadow_z_q;
    end else if (flg_z_ld) begin
      z_d = z_alu;
    end

    if (take_acc) begin
      i_d = 1'b0;
    end else if (flg_restore) begin
      if (RETI_SETS_I) i_d = 1'b1;
    end else if (int_clr) begin
      i_d = 1'b0;
    end else if (int_set) begin
      i_d = 1'b1;
    end
  end

  always_comb begin
    if (INT_EDGE) begin
      // a fresh edge coincident with int_take wins over the clear
      pending_d = (pending_q & ~take_acc) | (intr & ~intr_d_q);
    end else begin
      pending_d = intr;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pending_q && i_q) state_d = REQ;
      REQ: begin
        if (int_take)  state_d = SERVICE;
        else if (!i_d) state_d = IDLE;
      end
      SERVICE: if (flg_restore) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      i_q        <= 1'b0;
      shadow_c_q <= 1'b0;
      shadow_z_q <= 1'b0;
      pending_q  <= 1'b0;
      intr_d_q   <= 1'b0;
      int_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      z_q        <= z_d;
      i_q        <= i_d;
      shadow_c_q <= shadow_c_d;
      shadow_z_q <= shadow_z_d;
      pending_q  <= pending_d;
      intr_d_q   <= intr;
      int_req_q  <= (state_d == REQ);
    end
  end

  assign c_flag  = c_q;
  assign z_flag  = z_q;
  assign i_flag  = i_q;
  assign int_req = int_req_q;
  assign in_isr  = (state_q == SERVICE);

endmodule

// File: tb/tb_flag_int_unit.sv
// Directed-vector bench for flag_int_unit; expectations are queued by the
// driver and checked by an independent monitor on the falling edge.
module tb_flag_int_unit;

  logic clk = 1'b0;
  logic rst, c_alu, z_alu, flg_c_ld, flg_c_set, flg_c_clr, flg_z_ld;
  logic int_set, int_clr, intr, int_take, flg_restore;
  logic c_flag, z_flag, i_flag, int_req, in_isr;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  flag_int_unit #(.INT_EDGE(1'b1), .RETI_SETS_I(1'b1)) dut (
    .clk(clk), .rst(rst), .c_alu(c_alu), .z_alu(z_alu),
    .flg_c_ld(flg_c_ld), .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr),
    .flg_z_ld(flg_z_ld), .int_set(int_set), .int_clr(int_clr),
    .intr(intr), .int_take(int_take), .flg_restore(flg_restore),
    .c_flag(c_flag), .z_flag(z_flag), .i_flag(i_flag),
    .int_req(int_req), .in_isr(in_isr)
  );

  task automatic clr_in();
    rst = 0; c_alu = 0; z_alu = 0; flg_c_ld = 0; flg_c_set = 0; flg_c_clr = 0;
    flg_z_ld = 0; int_set = 0; int_clr = 0; intr = 0; int_take = 0; flg_restore = 0;
  endtask

  // exp = {c_flag, z_flag, i_flag, int_req, in_isr} after the coming edge
  task automatic tick(input string tag, input logic [4:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
    @(negedge clk);
    clr_in();
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        got = {c_flag, z_flag, i_flag, int_req, in_isr};
        total++;
        if (got !== e.exp) begin
          bad++;
          $display("FAIL %s: got czirs=%b expected %b", e.tag, got, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    clr_in();
    @(negedge clk);

    for (int unsigned k = 0; k < 2; k++) begin
      rst = 1; intr = 1; c_alu = 1; z_alu = 1;
      flg_c_ld = 1; flg_c_set = 1; flg_z_ld = 1; int_set = 1;
      tick("reset", 5'b00000);
    end
    tick("post_reset", 5'b00000);

    c_alu = 1; flg_c_ld = 1;           tick("c_ld", 5'b10000);
    flg_c_set = 1; flg_c_clr = 1;      tick("c_clr_over_set", 5'b00000);
    z_alu = 1; flg_z_ld = 1;           tick("z_ld", 5'b01000);
    flg_c_set = 1; flg_z_ld = 1; int_set = 1; tick("setup", 5'b10100);

    intr = 1;                          tick("intr_edge", 5'b10100);
    tick("req_rise", 5'b10110);
    tick("req_hold", 5'b10110);
    int_take = 1;                      tick("take", 5'b00001);
    flg_restore = 1;                   tick("restore", 5'b10100);
    tick("no_rereq", 5'b10100);

    int_clr = 1;                       tick("cli", 5'b10000);
    intr = 1;                          tick("masked_edge", 5'b10000);
    tick("masked_1", 5'b10000);
    tick("masked_2", 5'b10000);
    int_set = 1;                       tick("sei", 5'b10100);
    tick("sei_req", 5'b10110);
    int_take = 1;                      tick("take2", 5'b00001);

    intr = 1;                          tick("nest_edge", 5'b00001);
    tick("nest_hold1", 5'b00001);
    tick("nest_hold2", 5'b00001);
    flg_restore = 1;                   tick("nest_restore", 5'b10100);
    tick("nest_req", 5'b10110);

    int_take = 1; intr = 1;            tick("take_coinc", 5'b00001);
    flg_restore = 1;                   tick("coinc_restore", 5'b10100);
    tick("coinc_req", 5'b10110);
    int_take = 1;                      tick("take3", 5'b00001);
    flg_restore = 1;                   tick("restore3", 5'b10100);
    tick("idle3", 5'b10100);

    z_alu = 1; flg_z_ld = 1;           tick("z_set", 5'b11100);
    int_take = 1;                      tick("spurious_take", 5'b11100);
    tick("spurious_after", 5'b11100);

    intr = 1;                          tick("abort_edge", 5'b11100);
    tick("abort_req", 5'b11110);
    int_take = 1;                      tick("abort_take", 5'b00001);
    intr = 1;                          tick("abort_pend", 5'b00001);
    rst = 1;                           tick("abort_rst", 5'b00000);
    tick("abort_idle", 5'b00000);
    int_set = 1;                       tick("abort_sei", 5'b00100);
    tick("abort_no_pend", 5'b00100);
    intr = 1;                          tick("post_abort_edge", 5'b00100);
    tick("post_abort_req", 5'b00110);
    int_take = 1;                      tick("post_abort_take", 5'b00001);
    flg_restore = 1;                   tick("post_abort_ret", 5'b00100);

    intr = 1;                          tick("drop_edge", 5'b00100);
    tick("drop_req", 5'b00110);
    int_clr = 1;                       tick("drop_cli", 5'b00000);
    tick("drop_idle", 5'b00000);
    int_set = 1;                       tick("drop_sei", 5'b00100);
    tick("drop_rereq", 5'b00110);
    int_take = 1;                      tick("drop_take", 5'b00001);
    flg_restore = 1;                   tick("drop_ret", 5'b00100);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
